uart_tx_arbiter: RTL and testbench

Round-robin, packet-locking arbiter that shares the single UART transmit byte stream among `NUM_REQ` requesters. It sits between the requesters (command engine, debug port, status reporter, …) and the UART TX buffer input. Once a requester is granted, it holds the stream until it delivers its last byte or hits the `MAX_PKT` limit.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 103 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART TX sharing logic.
// Arbiter state encoding and default byte width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority picker: first set bit at or above ptr, wrapping.
// Pure combinational; shared with the RX-side sharing logic.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       gnt_any
);

  localparam int IW = $clog2(NUM_REQ);

  // Walk from the farthest slot down so the closest one to ptr wins.
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        gnt_id  = IW'(idx);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locking round-robin arbiter in front of the UART TX buffer.
// A grant is held until the last byte or the MAX_PKT beat limit.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = UART_DATA_W,
  parameter int MAX_PKT = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_en,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_valid,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        pkt_abort
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_PKT + 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(MAX_PKT - 1);
  localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);

  arb_state_t   state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] ptr;
  logic [IW-1:0] pick_id;
  logic          pick_any;
  logic [NUM_REQ-1:0] elig;
  logic [CW-1:0] beat_cnt;
  logic          beat;
  logic          at_limit;
  logic          cur_last;

  assign elig = req_valid & req_en;
  assign ptr  = (last_grant == LAST_ID) ? '0 : last_grant + 1'b1;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (elig),
    .ptr     (ptr),
    .gnt_id  (pick_id),
    .gnt_any (pick_any)
  );

  // Only the owner sees tx_ready; nothing here depends on req_valid.
  always_comb begin
    req_ready = '0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    if (state == LOCKED) begin
      tx_valid            = req_valid[grant_id];
      tx_data             = req_data[grant_id*DATA_W +: DATA_W];
      req_ready[grant_id] = tx_ready;
    end
  end

  assign busy     = (state == LOCKED);
  assign beat     = tx_valid && tx_ready;
  assign at_limit = (beat_cnt == CNT_LIM);
  assign cur_last = req_last[grant_id];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= LAST_ID;
      beat_cnt   <= '0;
      grant_id   <= '0;
      pkt_abort  <= 1'b0;
    end else begin
      pkt_abort <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id <= pick_id;
            beat_cnt <= '0;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            // A last byte on the limit beat is a normal end.
            if (cur_last || at_limit) begin
              state      <= IDLE;
              last_grant <= grant_id;
              pkt_abort  <= !cur_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a packet-level behavioural model.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXP = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_en;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [W-1:0]   tx_data;
  logic           tx_ready;
  logic [1:0]     grant_id;
  logic           busy;
  logic           pkt_abort;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (W),
    .MAX_PKT (MAXP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_en    (req_en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .pkt_abort (pkt_abort)
  );

  int n_vec = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // model: owner (or none), last owner, beats in current grant
  bit   m_busy;
  int   m_gid;
  int   m_last;
  int   m_cnt;
  bit   m_abort;
  bit   armed = 1'b0;
  logic [N-1:0] hs;

  logic         s_busy, s_txv, s_abort;
  logic [1:0]   s_gid;
  logic [W-1:0] s_txd;
  logic [N-1:0] s_rdy;

  int           rem [N];
  logic [W-1:0] dat [N];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_gid = 0; m_last = N - 1; m_cnt = 0; m_abort = 0;
    end else if (!m_busy) begin
      m_abort = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_last + 1 + k) % N;
        if (req_valid[j] && req_en[j]) begin
          m_busy = 1; m_gid = j; m_cnt = 0;
          break;
        end
      end
    end else begin
      m_abort = 0;
      if (req_valid[m_gid] && tx_ready) begin
        m_cnt++;
        if (req_last[m_gid]) begin
          m_busy = 0; m_last = m_gid;
        end else if (m_cnt == MAXP) begin
          m_busy = 0; m_last = m_gid; m_abort = 1;
        end
      end
    end
  endtask

  // Compare at negedge with the inputs that the next posedge samples.
  task automatic tick();
    logic [N-1:0] e_rdy;
    logic         e_v;
    logic [W-1:0] e_d;
    @(negedge clk);
    n_vec++;
    e_rdy = (m_busy && tx_ready) ? N'(1 << m_gid) : '0;
    e_v   = m_busy && req_valid[m_gid];
    e_d   = m_busy ? req_data[m_gid*W +: W] : '0;
    s_busy = busy; s_gid = grant_id; s_txv = tx_valid;
    s_txd = tx_data; s_rdy = req_ready; s_abort = pkt_abort;
    if (armed) begin
      chk("busy", 32'(busy), 32'(m_busy));
      if (m_busy) chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("tx_valid", 32'(tx_valid), 32'(e_v));
      chk("tx_data", 32'(tx_data), 32'(e_d));
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("pkt_abort", 32'(pkt_abort), 32'(m_abort));
    end
    hs = rst ? '0 : (e_rdy & req_valid);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_byte(int i, logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  initial begin
    int g[8];
    int ng;
    int bt[4];
    logic [W-1:0] got[4];
    int after;
    int idx;
    int beats[16];
    int nb;
    int ab_tick;
    int n_ab;
    int exp1[5];
    int exp4[8];
    exp1 = '{0, 1, 2, 3, 0};
    exp4 = '{1, 1, 1, 1, 3, 0, 1, 1};

    rst = 1'b1; req_en = '1; req_valid = '0; req_data = '0;
    req_last = '0; tx_ready = 1'b1;
    tick();
    armed = 1'b1;

    // all requesting single-byte packets: 0,1,2,3,0 one per two cycles
    do_reset();
    req_valid = '1; req_last = '1; tx_ready = 1'b1;
    for (int i = 0; i < N; i++) set_byte(i, W'(8'h10 + i));
    ng = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (s_busy && ng < 8) begin g[ng] = int'(s_gid); ng++; end
    end
    chk("rr_count", 32'(ng), 32'd5);
    for (int k = 0; k < 5; k++) chk("rr_order", 32'(g[k]), 32'(exp1[k]));

    // requester 2 three-byte packet, requester 0 waiting
    do_reset();
    req_valid = 4'b0100; req_last = '0; set_byte(2, 8'h41);
    tick();
    req_valid = 4'b0101; req_last[0] = 1'b1; set_byte(0, 8'h77);
    idx = 0; after = -1;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (s_busy && s_gid == 2 && s_txv && idx < 3) begin
        got[idx] = s_txd; bt[idx] = t; idx++;
        set_byte(2, W'(8'h41 + idx));
        req_last[2] = (idx == 2);
        req_valid[2] = (idx < 3);
      end else if (s_busy && idx == 3) begin
        after = int'(s_gid);
        break;
      end
    end
    chk("pkt_beats", 32'(idx), 32'd3);
    chk("pkt_b0", 32'(got[0]), 32'h41);
    chk("pkt_b1", 32'(got[1]), 32'h42);
    chk("pkt_b2", 32'(got[2]), 32'h43);
    chk("pkt_contig", 32'(bt[2] - bt[0]), 32'd2);
    chk("next_owner", 32'(after), 32'd0);

    // stall mid-packet for 10 cycles
    do_reset();
    req_valid = 4'b0010; req_last = '0; set_byte(1, 8'hA0);
    tick();
    tick();
    chk("stall_b0", 32'(s_txd), 32'hA0);
    set_byte(1, 8'hA1); tx_ready = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      chk("stall_data", 32'(s_txd), 32'hA1);
      chk("stall_rdy", 32'(s_rdy), 32'h0);
    end
    tx_ready = 1'b1;
    tick();
    chk("resume_rdy", 32'(s_rdy), 32'h2);
    set_byte(1, 8'hA2); req_last[1] = 1'b1;
    tick();
    chk("resume_b2", 32'(s_txd), 32'hA2);
    req_valid = '0;
    tick();
    chk("stall_release", 32'(s_busy), 32'd0);

    // limit: requester 1 streams 6 bytes without last
    do_reset();
    req_valid = 4'b0010; req_last = 4'b1001; set_byte(1, 8'hB0);
    set_byte(0, 8'hC0); set_byte(3, 8'hD3);
    tick();
    req_valid = 4'b1011;
    nb = 0; n_ab = 0; ab_tick = -1; idx = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (s_abort) begin n_ab++; ab_tick = t; end
      if (s_busy && s_txv && s_rdy != 0 && nb < 16) begin
        beats[nb] = int'(s_gid); nb++;
        if (s_gid == 1) begin
          idx++;
          set_byte(1, W'(8'hB0 + idx));
          if (idx == 6) req_valid[1] = 1'b0;
        end else begin
          req_valid[s_gid] = 1'b0;
        end
      end
    end
    chk("abort_count", 32'(n_ab), 32'd1);
    chk("abort_tick", 32'(ab_tick), 32'd4);
    chk("lim_beats", 32'(nb), 32'd8);
    for (int k = 0; k < 8; k++) chk("lim_order", 32'(beats[k]), 32'(exp4[k]));

    // masked requester never wins until enabled
    do_reset();
    req_en = 4'b1011; req_valid = 4'b0100; req_last = '1;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("masked_idle", 32'(s_busy), 32'd0);
    end
    req_en = '1;
    tick();
    tick();
    chk("unmask_busy", 32'(s_busy), 32'd1);
    chk("unmask_gid", 32'(s_gid), 32'd2);

    // reset during beat 2 of a 5-byte packet
    do_reset();
    req_valid = 4'b0001; req_last = '0; set_byte(0, 8'h50);
    tick();
    tick();
    set_byte(0, 8'h51); rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = '1; req_last = '1;
    tick();
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_txv", 32'(s_txv), 32'd0);
    tick();
    chk("rst_first", 32'(s_gid), 32'd0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < N; i++) begin rem[i] = 0; dat[i] = '0; end
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(0, 299) == 0);
      req_en = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      tx_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 2) == 0) rem[i] = $urandom_range(1, 6);
        req_valid[i] = (rem[i] != 0) && ($urandom_range(0, 3) != 0);
        req_last[i] = (rem[i] == 1);
        set_byte(i, dat[i]);
      end
      tick();
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin rem[i]--; dat[i] = dat[i] + 1'b1; end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
